nmi_demux: RTL and testbench

NMI_DEMUX -- requirements
Module: nmi_demux

---
 rtl/nmi_demux_pkg.sv | 38 +++
 rtl/nmi_demux_prienc.sv | 24 ++
 rtl/nmi_demux.sv | 176 +++++++++++++++++
 tb/tb_nmi_demux.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmi_demux_pkg.sv
// NMI demux shared types and defaults.
// Holds FSM/error enums and default decode maps.
package nmi_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_UNMAP = 2'd1,
    ERR_TMO   = 2'd2
  } err_code_t;

  localparam logic [31:0] ERR_RDATA_DFLT = 32'hDEAD_BEEF;

  localparam int MAX_SLV = 16;

  // Slave i owns the 256 MiB window starting at i << 28.
  function automatic logic [MAX_SLV-1:0][31:0] dflt_base();
    logic [MAX_SLV-1:0][31:0] b;
    for (int i = 0; i < MAX_SLV; i++) begin
      b[i] = 32'(i) << 28;
    end
    return b;
  endfunction

  localparam logic [MAX_SLV-1:0][31:0] DFLT_BASE = dflt_base();
  localparam logic [MAX_SLV-1:0][31:0] DFLT_MASK =
    {MAX_SLV{32'hF000_0000}};

  function automatic int sel_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nmi_demux_prienc.sv
// Lowest-index-wins priority encoder for the hit vector.
// any is set when at least one hit bit is high.
module nmi_demux_prienc #(
  parameter int N = 11,
  parameter int W = 4
) (
  input  logic [N-1:0] hit,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top so the lowest set bit is written last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nmi_demux.sv
// NMI address demux: one master to SLV_NUM slaves.
// Optional stall timeout: define NMI_DEMUX_TIMEOUT_EN.
module nmi_demux
  import nmi_demux_pkg::*;
#(
  parameter int SLV_NUM = 11,
  parameter logic [SLV_NUM-1:0][31:0] SLV_BASE =
    DFLT_BASE[SLV_NUM-1:0],
  parameter logic [SLV_NUM-1:0][31:0] SLV_MASK =
    DFLT_MASK[SLV_NUM-1:0],
  parameter int TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DFLT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m_valid_i,
  input  logic [31:0]              m_addr_i,
  input  logic [31:0]              m_wdata_i,
  input  logic [3:0]               m_wstrb_i,
  output logic                     m_ready_o,
  output logic [31:0]              m_rdata_o,
  output logic [SLV_NUM-1:0]       s_valid_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  output logic [3:0]               s_wstrb_o,
  input  logic [SLV_NUM-1:0]       s_ready_i,
  input  logic [SLV_NUM-1:0][31:0] s_rdata_i,
  output logic                     err_o,
  output logic [31:0]              err_addr_o,
  output logic [1:0]               err_code_o
);

  localparam int SEL_W = sel_width(SLV_NUM);

  state_t           state;
  state_t           state_nx;
  logic [SLV_NUM-1:0] hit;
  logic [SEL_W-1:0] hit_idx;
  logic             hit_any;
  logic [SEL_W-1:0] sel_q;
  logic             latch_sel;
  logic             go_err;
  err_code_t        err_kind;
  err_code_t        err_code_q;
  logic [31:0]      err_addr_q;
  logic             tmo;

  assign s_addr_o   = m_addr_i;
  assign s_wdata_o  = m_wdata_i;
  assign s_wstrb_o  = m_wstrb_i;
  assign err_code_o = err_code_q;
  assign err_addr_o = err_addr_q;

  // Address match against every slave window.
  always_comb begin
    hit = '0;
    for (int i = 0; i < SLV_NUM; i++) begin
      hit[i] = (m_addr_i & SLV_MASK[i]) == SLV_BASE[i];
    end
  end

  nmi_demux_prienc #(
    .N(SLV_NUM),
    .W(SEL_W)
  ) u_prienc (
    .hit(hit),
    .idx(hit_idx),
    .any(hit_any)
  );

`ifdef NMI_DEMUX_TIMEOUT_EN
  localparam int CNT_W = sel_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;

  assign tmo = cnt_q == CNT_W'(TIMEOUT_CYC - 1);

  // Stall counter: zero outside ACCESS, so each entry starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state != ST_ACCESS) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Next state and the combinational master response.
  always_comb begin
    state_nx  = state;
    m_ready_o = 1'b0;
    m_rdata_o = '0;
    err_o     = 1'b0;
    latch_sel = 1'b0;
    go_err    = 1'b0;
    err_kind  = ERR_NONE;
    unique case (state)
      ST_IDLE: begin
        if (m_valid_i) begin
          if (hit_any) begin
            state_nx  = ST_ACCESS;
            latch_sel = 1'b1;
          end else begin
            state_nx = ST_ERR;
            go_err   = 1'b1;
            err_kind = ERR_UNMAP;
          end
        end
      end
      ST_ACCESS: begin
        if (!m_valid_i) begin
          state_nx = ST_IDLE;
        end else if (s_ready_i[sel_q]) begin
          state_nx  = ST_IDLE;
          m_ready_o = 1'b1;
          m_rdata_o = s_rdata_i[sel_q];
        end else if (tmo) begin
          state_nx = ST_ERR;
          go_err   = 1'b1;
          err_kind = ERR_TMO;
        end
      end
      ST_ERR: begin
        state_nx  = ST_IDLE;
        m_ready_o = 1'b1;
        m_rdata_o = ERR_RDATA;
        err_o     = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Latch the winning slave index at decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q <= '0;
    end else if (latch_sel) begin
      sel_q <= hit_idx;
    end
  end

  // Error info is captured on ERR entry and held until the next error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else if (go_err) begin
      err_code_q <= err_kind;
      err_addr_q <= m_addr_i;
    end
  end

  // Only the latched slave sees valid, and only while in ACCESS.
  always_comb begin
    s_valid_o = '0;
    if (state == ST_ACCESS) begin
      s_valid_o[sel_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_nmi_demux.sv
// Randomized self-checking bench for nmi_demux.
// Transaction-level model predicts every cycle of each access.
module tb_nmi_demux;

  localparam int N = 6;
  localparam int TMO = 16;
  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;
  localparam logic [N-1:0][31:0] BASE = {
    32'h2200_0000, 32'h4000_0000, 32'h3000_0000,
    32'h2000_0000, 32'h1000_1000, 32'h0000_0000
  };
  localparam logic [N-1:0][31:0] MASK = {
    32'hFF00_0000, 32'hF000_0000, 32'hF000_0000,
    32'hF000_0000, 32'hFF00_FF00, 32'hF000_0000
  };

  logic clk = 1'b0;
  logic rst_i;
  logic m_valid_i;
  logic [31:0] m_addr_i;
  logic [31:0] m_wdata_i;
  logic [3:0] m_wstrb_i;
  logic m_ready_o;
  logic [31:0] m_rdata_o;
  logic [N-1:0] s_valid_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [3:0] s_wstrb_o;
  logic [N-1:0] s_ready_i;
  logic [N-1:0][31:0] s_rdata_i;
  logic err_o;
  logic [31:0] err_addr_o;
  logic [1:0] err_code_o;

  nmi_demux #(
    .SLV_NUM(N),
    .SLV_BASE(BASE),
    .SLV_MASK(MASK),
    .TIMEOUT_CYC(TMO),
    .ERR_RDATA(ERR_RD)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .m_valid_i(m_valid_i),
    .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i),
    .m_wstrb_i(m_wstrb_i),
    .m_ready_o(m_ready_o),
    .m_rdata_o(m_rdata_o),
    .s_valid_o(s_valid_o),
    .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o),
    .s_ready_i(s_ready_i),
    .s_rdata_i(s_rdata_i),
    .err_o(err_o),
    .err_addr_o(err_addr_o),
    .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [N-1:0] e_sv;
  logic e_rdy;
  logic [31:0] e_rd;
  logic e_err;
  logic [1:0] held_code;
  logic [31:0] held_addr;

  int rsp_cnt = 0;
  logic [31:0] last_rd = '0;
  logic [N-1:0] last_sv = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lowest-index slave whose window contains a, or -1.
  function automatic int target(input logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & MASK[i]) == BASE[i]) return i;
    end
    return -1;
  endfunction

  // Per-cycle comparison against the model's expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst_i) begin
        chk("s_valid", 32'(s_valid_o), 32'(e_sv));
        chk("m_ready", 32'(m_ready_o), 32'(e_rdy));
        chk("m_rdata", m_rdata_o, e_rd);
        chk("err", 32'(err_o), 32'(e_err));
        chk("err_code", 32'(err_code_o), 32'(held_code));
        chk("err_addr", err_addr_o, held_addr);
        chk("s_addr", s_addr_o, m_addr_i);
        chk("s_wdata", s_wdata_o, m_wdata_i);
        chk("s_wstrb", 32'(s_wstrb_o), 32'(m_wstrb_i));
        if (m_ready_o) begin
          rsp_cnt++;
          last_rd = m_rdata_o;
        end
        if (s_valid_o != '0) last_sv = s_valid_o;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    s_ready_i = N'($urandom);
    for (int i = 0; i < N; i++) s_rdata_i[i] = $urandom;
  endtask

  task automatic idle_exp();
    e_sv = '0;
    e_rdy = 1'b0;
    e_rd = '0;
    e_err = 1'b0;
  endtask

  // One request: ready on ACCESS cycle d (0 = never),
  // master abort on ACCESS cycle ab (0 = never), then gap idle cycles.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input int d, input int ab,
                         input int gap, input bit frc,
                         input logic [31:0] frd);
    int t;
    t = target(a);
    m_valid_i = 1'b1;
    m_addr_i = a;
    m_wdata_i = wd;
    m_wstrb_i = ws;
    noise();
    idle_exp();
    nxt();
    if (t < 0) begin
      noise();
      held_code = 2'd1;
      held_addr = a;
      e_rdy = 1'b1;
      e_rd = ERR_RD;
      e_err = 1'b1;
      nxt();
    end else begin
      for (int k = 1; k <= 2000; k++) begin
        noise();
        s_ready_i[t] = 1'b0;
        idle_exp();
        e_sv = N'(1) << t;
        if (k == ab) begin
          m_valid_i = 1'b0;
          s_ready_i[t] = 1'b1;
          nxt();
          break;
        end
        if (k == d) begin
          s_ready_i[t] = 1'b1;
          if (frc) s_rdata_i[t] = frd;
          e_rdy = 1'b1;
          e_rd = s_rdata_i[t];
          nxt();
          break;
        end
`ifdef NMI_DEMUX_TIMEOUT_EN
        if (k == TMO) begin
          nxt();
          noise();
          idle_exp();
          held_code = 2'd2;
          held_addr = a;
          e_rdy = 1'b1;
          e_rd = ERR_RD;
          e_err = 1'b1;
          nxt();
          break;
        end
`endif
        nxt();
      end
    end
    for (int g = 0; g < gap; g++) begin
      m_valid_i = 1'b0;
      m_addr_i = $urandom;
      noise();
      idle_exp();
      nxt();
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 3))
      0: a = 32'h1000_1000 | (a & 32'h00FF_00FF);
      1: a = {4'h2, 4'h2, a[23:0]};
      default: ;
    endcase
    return a;
  endfunction

  int r0;
  int d;
  int ab;

  initial begin
    rst_i = 1'b1;
    m_valid_i = 1'b0;
    m_addr_i = '0;
    m_wdata_i = '0;
    m_wstrb_i = '0;
    s_ready_i = '0;
    s_rdata_i = '0;
    held_code = '0;
    held_addr = '0;
    idle_exp();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", 32'(s_valid_o), 32'd0);
    chk("rst_m_ready", 32'(m_ready_o), 32'd0);
    chk("rst_err_code", 32'(err_code_o), 32'd0);
    rst_i = 1'b0;
    chk_en = 1'b1;

    // Slave 1 window, ready on third ACCESS cycle.
    r0 = rsp_cnt;
    run_txn(32'h1000_1004, 32'h0, 4'h0, 3, 0, 1, 1'b1, 32'h1234_5678);
    chk("p1_sv", 32'(last_sv), 32'h0000_0002);
    chk("p1_rdata", last_rd, 32'h1234_5678);
    chk("p1_rsp", rsp_cnt - r0, 1);

    // Unmapped access.
    r0 = rsp_cnt;
    run_txn(32'h9000_0000, 32'h0, 4'h0, 1, 0, 1, 1'b0, '0);
    chk("p2_rdata", last_rd, 32'hDEAD_BEEF);
    chk("p2_code", 32'(err_code_o), 32'd1);
    chk("p2_eaddr", err_addr_o, 32'h9000_0000);
    chk("p2_rsp", rsp_cnt - r0, 1);

    // Overlap of slaves 2 and 5.
    run_txn(32'h2200_0010, 32'h0, 4'h0, 2, 0, 1, 1'b0, '0);
    chk("p3_sv", 32'(last_sv), 32'h0000_0004);

    // Back-to-back writes with valid held high.
    r0 = rsp_cnt;
    run_txn(32'h3000_0040, 32'hA5A5_0001, 4'b0011, 2, 0, 0,
            1'b0, '0);
    run_txn(32'h4000_0080, 32'h5A5A_0002, 4'b1100, 1, 0, 1,
            1'b0, '0);
    chk("p4_rsp", rsp_cnt - r0, 2);
    chk("p4_sv", 32'(last_sv), 32'h0000_0010);

    // Slave never readies.
    r0 = rsp_cnt;
`ifdef NMI_DEMUX_TIMEOUT_EN
    run_txn(32'h3000_0000, 32'h0, 4'h0, 0, 0, 1, 1'b0, '0);
    chk("p5_code", 32'(err_code_o), 32'd2);
    chk("p5_rdata", last_rd, 32'hDEAD_BEEF);
    chk("p5_rsp", rsp_cnt - r0, 1);
`else
    run_txn(32'h3000_0000, 32'h0, 4'h0, 0, 1001, 1, 1'b0, '0);
    chk("p5_rsp", rsp_cnt - r0, 0);
`endif

    // Reset in the middle of an access.
    m_valid_i = 1'b1;
    m_addr_i = 32'h4000_0100;
    noise();
    idle_exp();
    nxt();
    noise();
    s_ready_i[4] = 1'b0;
    e_sv = N'(1) << 4;
    nxt();
    noise();
    s_ready_i[4] = 1'b0;
    #1;
    rst_i = 1'b1;
    #1;
    chk("r_s_valid", 32'(s_valid_o), 32'd0);
    chk("r_m_ready", 32'(m_ready_o), 32'd0);
    chk("r_m_rdata", m_rdata_o, 32'd0);
    chk("r_err", 32'(err_o), 32'd0);
    chk("r_err_code", 32'(err_code_o), 32'd0);
    chk("r_err_addr", err_addr_o, 32'd0);
    held_code = '0;
    held_addr = '0;
    m_valid_i = 1'b0;
    idle_exp();
    nxt();
    nxt();
    rst_i = 1'b0;
    r0 = rsp_cnt;
    run_txn(32'h4000_0100, 32'h1, 4'hF, 2, 0, 1, 1'b1, 32'hCAFE_0001);
    chk("r_rsp", rsp_cnt - r0, 1);
    chk("r_rdata", last_rd, 32'hCAFE_0001);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(1, 6);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, d) : 0;
      run_txn(rnd_addr(), $urandom, 4'($urandom), d, ab,
              $urandom_range(0, 2), 1'b0, '0);
    end

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
